// File: rtl/sobel_pkg.sv
// Shared types and constants for the pixel return path.
//   tx_state_e : serializer FSM state (also exported on the debug port)
//   SYNC0_C    : first frame-sync marker byte
//   SYNC1_C    : second frame-sync marker byte
package sobel_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC0 = 3'd1,
    S_SYNC1 = 3'd2,
    S_B0    = 3'd3,
    S_B1    = 3'd4,
    S_B2    = 3'd5
  } tx_state_e;

  localparam logic [7:0] SYNC0_C = 8'hA5;
  localparam logic [7:0] SYNC1_C = 8'h5A;

endpackage

// File: rtl/frame_counter.sv
// Pixel/line position tracker, shared between the TX serializer and RX packer.
//   clk_i, rstn_i  : clock, asynchronous active-low reset
//   inc_i          : one pixel finished this cycle
//   x_o, y_o       : position of the current pixel (column, line)
//   line_last_o    : current pixel is the last of its line
//   frame_last_o   : current pixel is the last of the frame
module frame_counter #(
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480,
  localparam int XW = (LINE_W_P  > 1) ? $clog2(LINE_W_P)  : 1,
  localparam int YW = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          inc_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_last_o,
  output logic          frame_last_o
);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign line_last_o  = (x_q == XW'(LINE_W_P - 1));
  assign frame_last_o = line_last_o && (y_q == YW'(FRAME_H_P - 1));

  // x and y wrap together on the last pixel of the frame.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (inc_i) begin
      if (line_last_o) begin
        x_q <= '0;
        y_q <= frame_last_o ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_byte_tx.sv
// Return-path serializer: one {B,G,R} pixel in, bytes R, G, B out, with an
// optional two-byte sync marker ahead of the first pixel of every frame.
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   data_i/valid_i/ready_o : pixel input stream
//   data_o/valid_o/ready_i : byte output stream
//   line_end_o           : qualifies the B byte of the last pixel of a line
//   frame_end_o          : qualifies the B byte of the last pixel of a frame
//   dbg_state_o          : current FSM state
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and data stable until that edge;
// ready may be asserted without valid. Here valid_o/data_o are registered and
// only change after a transfer; ready_o is high in S_IDLE and follows ready_i
// in S_B2 so a new pixel can be taken in the cycle the last byte leaves.
module pixel_byte_tx
  import sobel_pkg::*;
#(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480,
  parameter int SYNC_EN_P = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [3*WIDTH_P-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [WIDTH_P-1:0]   data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 line_end_o,
  output logic                 frame_end_o,
  output tx_state_e            dbg_state_o
);

  localparam int XW = (LINE_W_P  > 1) ? $clog2(LINE_W_P)  : 1;
  localparam int YW = (FRAME_H_P > 1) ? $clog2(FRAME_H_P) : 1;

  tx_state_e            state_q, state_d, start_state;
  logic [3*WIDTH_P-1:0] pix_q, pix_d;
  logic [WIDTH_P-1:0]   byte_d;
  logic                 accept, take, inc;
  logic                 frame_start;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 line_last, frame_last;

  assign dbg_state_o = state_q;
  assign ready_o     = (state_q == S_IDLE) || ((state_q == S_B2) && ready_i);
  assign accept      = valid_i && ready_o;
  assign take        = valid_o && ready_i;
  assign inc         = (state_q == S_B2) && take;

  frame_counter #(
    .LINE_W_P  (LINE_W_P),
    .FRAME_H_P (FRAME_H_P)
  ) u_frame_counter (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .inc_i        (inc),
    .x_o          (x),
    .y_o          (y),
    .line_last_o  (line_last),
    .frame_last_o (frame_last)
  );

  // On a zero-bubble accept the counters have not stepped yet, so the next
  // pixel starts a frame exactly when the one now finishing ends a frame.
  assign frame_start = inc ? frame_last : ((x == '0) && (y == '0));
  assign start_state = ((SYNC_EN_P != 0) && frame_start) ? S_SYNC0 : S_B0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = start_state;
      S_SYNC0: if (take)   state_d = S_SYNC1;
      S_SYNC1: if (take)   state_d = S_B0;
      S_B0:    if (take)   state_d = S_B1;
      S_B1:    if (take)   state_d = S_B2;
      S_B2:    if (take)   state_d = accept ? start_state : S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  assign pix_d = accept ? data_i : pix_q;

  // The output byte is a pure function of the next state and pixel, so it is
  // recomputed identically (and therefore stable) while a byte is stalled.
  always_comb begin
    byte_d = '0;
    case (state_d)
      S_SYNC0: byte_d = WIDTH_P'(SYNC0_C);
      S_SYNC1: byte_d = WIDTH_P'(SYNC1_C);
      S_B0:    byte_d = pix_d[WIDTH_P-1:0];
      S_B1:    byte_d = pix_d[2*WIDTH_P-1:WIDTH_P];
      S_B2:    byte_d = pix_d[3*WIDTH_P-1:2*WIDTH_P];
      default: byte_d = '0;
    endcase
  end

  // Counters only move when a B byte leaves, which never coincides with
  // entering or holding S_B2, so x/y here belong to the pixel being sent.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      line_end_o  <= 1'b0;
      frame_end_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      data_o      <= byte_d;
      valid_o     <= (state_d != S_IDLE);
      line_end_o  <= (state_d == S_B2) && line_last;
      frame_end_o <= (state_d == S_B2) && frame_last;
    end
  end

endmodule
